// File: rtl/play_instrument_poly.sv
// play_instrument_poly: polyphonic ZBT sample player and mic recorder between AC97 and ZBT.
// Ports: clock/reset_n (async active-low); ready = AC97 frame pulse; record selects mic capture;
//   from_ac97_data = mic sample; voice_trigger/voice_stop = per-voice pulses; voice_loop = per-voice
//   wrap enable; voice_base/rec_base = ZBT word bases; data_in/data_out/address/we_ZBT = ZBT port;
//   to_ac97_data = mixed sample; voice_active, rec_done, overrun = status.
module play_instrument_poly #(
   parameter int NUM_VOICES    = 4,
   parameter int RECORDING_LEN = 32768,
   parameter int ADDR_W        = 19,
   parameter int ZBT_LATENCY   = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         ready,
   input  logic                         record,
   input  logic [7:0]                   from_ac97_data,
   input  logic [NUM_VOICES-1:0]        voice_trigger,
   input  logic [NUM_VOICES-1:0]        voice_stop,
   input  logic [NUM_VOICES-1:0]        voice_loop,
   input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
   input  logic [ADDR_W-1:0]            rec_base,
   input  logic [35:0]                  data_in,
   output logic [35:0]                  data_out,
   output logic [ADDR_W-1:0]            address,
   output logic                         we_ZBT,
   output logic [7:0]                   to_ac97_data,
   output logic [NUM_VOICES-1:0]        voice_active,
   output logic                         rec_done,
   output logic                         overrun
);
   localparam int IW = $clog2(RECORDING_LEN);
   localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
   localparam int AW = 8 + $clog2(NUM_VOICES);
   localparam int CW = ZBT_LATENCY > 1 ? $clog2(ZBT_LATENCY) : 1;
   localparam logic signed [AW-1:0] SMAX = AW'(127);
   localparam logic signed [AW-1:0] SMIN = AW'(-128);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, MIX} state_t;
   state_t                              state_q, state_d;
   logic [VW-1:0]                       v_q, v_d;
   logic [CW-1:0]                       cnt_q, cnt_d;
   logic signed [AW-1:0]                acc_q, acc_d;
   logic [NUM_VOICES-1:0][IW-1:0]       idx_q, idx_d;
   logic [NUM_VOICES-1:0]               active_q, active_d, trig_q, trig_d, stop_q, stop_d, trig_e, stop_e;
   logic [IW-1:0]                       ptr_q, ptr_d, rptr;
   logic [23:0]                         pack_q, pack_d;
   logic                                rec_done_q, rec_done_d, rec_prev_q, rec_prev_d, rdone;
   logic [ADDR_W-1:0]                   address_q, address_d;
   logic [35:0]                         data_out_q, data_out_d;
   logic                                we_q, we_d, overrun_q, overrun_d;
   logic [7:0]                          out_q, out_d, lane_b;
   logic [NUM_VOICES-1:0][ADDR_W-1:0]   bases;
   logic                                unused_hi;
   assign bases        = voice_base;
   assign unused_hi    = ^data_in[35:32];
   assign data_out     = data_out_q;
   assign address      = address_q;
   assign we_ZBT       = we_q;
   assign to_ac97_data = out_q;
   assign voice_active = active_q;
   assign rec_done     = rec_done_q;
   assign overrun      = overrun_q;
   always_comb begin
      state_d    = state_q;
      v_d        = v_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      active_d   = active_q;
      trig_e     = trig_q | voice_trigger;
      stop_e     = stop_q | voice_stop;
      trig_d     = trig_e;
      stop_d     = stop_e;
      ptr_d      = ptr_q;
      pack_d     = pack_q;
      rec_done_d = rec_done_q;
      rec_prev_d = rec_prev_q;
      address_d  = address_q;
      data_out_d = '0;
      we_d       = 1'b1;
      out_d      = out_q;
      overrun_d  = overrun_q | (ready && state_q != IDLE);
      // entering record mode restarts the recording from sample 0
      rptr       = rec_prev_q ? ptr_q : '0;
      rdone      = rec_prev_q & rec_done_q;
      lane_b     = data_in[{idx_q[v_q][1:0], 3'b000} +: 8];
      case (state_q)
         IDLE: begin
            if (ready && record) begin
               rec_prev_d = 1'b1;
               ptr_d      = rptr;
               rec_done_d = rdone;
               if (!rdone) begin
                  pack_d     = (rptr[1:0] == 2'd0 ? 24'd0 : pack_q) | (24'(from_ac97_data) << {rptr[1:0], 3'b000});
                  out_d      = from_ac97_data;
                  ptr_d      = rptr + 1'b1;
                  rec_done_d = &rptr;
                  if (&rptr[1:0]) begin
                     address_d  = rec_base + ADDR_W'(rptr >> 2);
                     data_out_d = {4'b0, from_ac97_data, pack_q};
                     we_d       = 1'b0;
                  end
               end
            end else if (ready) begin
               rec_prev_d = 1'b0;
               trig_d     = '0;
               stop_d     = '0;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (trig_e[i]) begin
                     active_d[i] = 1'b1;
                     idx_d[i]    = '0;
                  end else if (stop_e[i]) active_d[i] = 1'b0;
               end
               v_d     = '0;
               acc_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (active_q[v_q]) begin
               address_d = bases[v_q] + ADDR_W'(idx_q[v_q] >> 2);
               cnt_d     = '0;
               state_d   = WAIT;
            end else if (v_q == VW'(NUM_VOICES - 1)) state_d = MIX;
            else v_d = v_q + 1'b1;
         end
         WAIT: begin
            if (cnt_q == CW'(ZBT_LATENCY - 1)) state_d = ACC;
            else cnt_d = cnt_q + 1'b1;
         end
         ACC: begin
            acc_d        = acc_q + AW'($signed(lane_b));
            idx_d[v_q]   = idx_q[v_q] + 1'b1;
            if (&idx_q[v_q] && !voice_loop[v_q]) active_d[v_q] = 1'b0;
            state_d      = v_q == VW'(NUM_VOICES - 1) ? MIX : ISSUE;
            v_d          = v_q == VW'(NUM_VOICES - 1) ? v_q : v_q + 1'b1;
         end
         MIX: begin
            out_d   = acc_q > SMAX ? 8'h7f : acc_q < SMIN ? 8'h80 : acc_q[7:0];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         v_q        <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         active_q   <= '0;
         trig_q     <= '0;
         stop_q     <= '0;
         ptr_q      <= '0;
         pack_q     <= '0;
         rec_done_q <= 1'b0;
         rec_prev_q <= 1'b0;
         address_q  <= '0;
         data_out_q <= '0;
         we_q       <= 1'b1;
         out_q      <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         v_q        <= v_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         active_q   <= active_d;
         trig_q     <= trig_d;
         stop_q     <= stop_d;
         ptr_q      <= ptr_d;
         pack_q     <= pack_d;
         rec_done_q <= rec_done_d;
         rec_prev_q <= rec_prev_d;
         address_q  <= address_d;
         data_out_q <= data_out_d;
         we_q       <= we_d;
         out_q      <= out_d;
         overrun_q  <= overrun_d;
      end
   end
endmodule

// File: tb/tb_play_instrument_poly.sv
// tb_play_instrument_poly: scoreboard bench for play_instrument_poly with a ZBT memory model.
module tb_play_instrument_poly;
   localparam int NV = 4, RL = 8, AW = 19, L = 2, BOUND = 2 + NV * (L + 2);
   logic clock = 0, reset_n = 0, ready = 0, record = 0;
   logic [7:0] mic = 0;
   logic [NV-1:0] trig = 0, stop = 0, loop = 0;
   logic [NV*AW-1:0] vbase = 0;
   logic [AW-1:0] rbase = 0;
   logic [35:0] data_in = 0, data_out;
   logic [AW-1:0] address;
   logic we_ZBT, rec_done, overrun;
   logic [7:0] to_ac97;
   logic [NV-1:0] vact;
   play_instrument_poly #(.NUM_VOICES(NV), .RECORDING_LEN(RL), .ADDR_W(AW), .ZBT_LATENCY(L)) dut (
      .clock(clock), .reset_n(reset_n), .ready(ready), .record(record), .from_ac97_data(mic),
      .voice_trigger(trig), .voice_stop(stop), .voice_loop(loop), .voice_base(vbase), .rec_base(rbase),
      .data_in(data_in), .data_out(data_out), .address(address), .we_ZBT(we_ZBT),
      .to_ac97_data(to_ac97), .voice_active(vact), .rec_done(rec_done), .overrun(overrun));
   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;
   // ZBT model: data appears L cycles after the address
   logic [35:0] zbt [int];
   logic [35:0] rmem [int];
   logic [AW-1:0] a1 = 0;
   always @(posedge clock) begin
      a1 <= address;
      data_in <= zbt.exists(int'(a1)) ? zbt[int'(a1)] : 36'h0;
      if (!we_ZBT) zbt[int'(address)] = data_out;
   end
   typedef struct {int due; logic [7:0] out; logic [NV-1:0] act; logic rd; logic ov;} exp_t;
   typedef struct {logic [AW-1:0] a; logic [35:0] d;} wr_t;
   exp_t sbq[$];
   wr_t wq[$];
   int checks = 0, errors = 0;
   // reference model state
   logic [NV-1:0] m_act = 0, pend_t = 0, pend_s = 0;
   int m_idx[NV];
   logic rec_prev = 0, rdone = 0, m_ov = 0;
   int rptr = 0;
   logic [31:0] pack = 0;
   logic [7:0] last_out = 0;
   task automatic chk(input string n, input logic [63:0] g, input logic [63:0] w);
      checks++;
      if (g !== w) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, g, w);
      end
   endtask
   always @(negedge clock) begin
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
         exp_t e;
         e = sbq.pop_front();
         chk("mix_out", to_ac97, e.out);
         chk("voice_active", vact, e.act);
         chk("rec_done", rec_done, e.rd);
         chk("overrun", overrun, e.ov);
      end
      if (reset_n && !we_ZBT) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got addr %0h data %0h want no write", address, data_out);
         end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", address, w.a);
            chk("wr_data", data_out, w.d);
         end
      end
   end
   task automatic poke(input int a, input logic [35:0] w);
      zbt[a] = w;
      rmem[a] = w;
   endtask
   task automatic model_reset();
      m_act = 0; pend_t = 0; pend_s = 0; rec_prev = 0; rdone = 0; m_ov = 0; rptr = 0; pack = 0; last_out = 0;
      for (int v = 0; v < NV; v++) m_idx[v] = 0;
   endtask
   task automatic model_ready();
      exp_t e;
      if (record) begin
         if (!rec_prev) begin rptr = 0; rdone = 0; end
         if (!rdone) begin
            pack[8*(rptr%4) +: 8] = mic;
            last_out = mic;
            if (rptr % 4 == 3) begin
               wr_t w;
               w.a = AW'((int'(rbase) + rptr / 4) % (1 << AW));
               w.d = {4'b0, pack};
               wq.push_back(w);
               rmem[int'(w.a)] = w.d;
            end
            if (rptr == RL - 1) rdone = 1;
            rptr++;
         end
         rec_prev = 1;
      end else begin
         int sum = 0;
         for (int v = 0; v < NV; v++) begin
            if (pend_t[v]) begin m_act[v] = 1; m_idx[v] = 0; end
            else if (pend_s[v]) m_act[v] = 0;
         end
         pend_t = 0; pend_s = 0;
         for (int v = 0; v < NV; v++) if (m_act[v]) begin
            int a;
            logic [35:0] w;
            logic [7:0] b;
            a = (int'(vbase[v*AW +: AW]) + m_idx[v] / 4) % (1 << AW);
            w = rmem.exists(a) ? rmem[a] : 36'h0;
            b = w[8*(m_idx[v]%4) +: 8];
            sum += int'($signed(b));
            m_idx[v]++;
            if (m_idx[v] == RL) begin
               m_idx[v] = 0;
               if (!loop[v]) m_act[v] = 0;
            end
         end
         last_out = sum > 127 ? 8'h7f : sum < -128 ? 8'h80 : 8'(sum);
         rec_prev = 0;
      end
      e.due = cyc + BOUND + 1; e.out = last_out; e.act = m_act; e.rd = rdone; e.ov = m_ov;
      sbq.push_back(e);
   endtask
   task automatic do_ready();
      model_ready();
      ready = 1;
      @(posedge clock); #1 ready = 0;
      repeat (BOUND + 6 + $urandom_range(0, 4)) @(posedge clock);
      #1;
   endtask
   task automatic pulse(input logic [NV-1:0] t, input logic [NV-1:0] s);
      trig = t; stop = s; pend_t |= t; pend_s |= s;
      @(posedge clock); #1 trig = 0; stop = 0;
   endtask
   task automatic set_base(input int v, input int b);
      vbase[v*AW +: AW] = AW'(b);
   endtask
   task automatic check_reset_outputs(input string n);
      chk({n, "_address"}, address, 0);
      chk({n, "_we"}, we_ZBT, 1);
      chk({n, "_data_out"}, data_out, 0);
      chk({n, "_out"}, to_ac97, 0);
      chk({n, "_active"}, vact, 0);
      chk({n, "_rec_done"}, rec_done, 0);
      chk({n, "_overrun"}, overrun, 0);
   endtask
   initial begin
      model_reset();
      poke('h100, 36'h0_04_03_02_01);
      poke('h101, 36'h0_08_07_06_05);
      poke('h500, 36'h0_7f_7f_7f_7f);
      poke('h600, 36'h0_80_80_80_80);
      poke('h700, 36'h0_00_00_00_10);
      poke('h701, 36'h0_00_00_00_f0);
      for (int a = 'h1000; a < 'h1010; a++) poke(a, {4'b0, 32'($urandom)});
      repeat (3) @(posedge clock);
      #1 check_reset_outputs("reset");
      reset_n = 1;
      @(posedge clock); #1;
      set_base(0, 'h100);
      pulse(4'b0001, 4'b0000);
      for (int i = 0; i < 9; i++) do_ready();
      loop = 4'b0001;
      pulse(4'b0001, 4'b0000);
      for (int i = 0; i < 9; i++) do_ready();
      for (int v = 0; v < NV; v++) set_base(v, 'h500);
      loop = 4'b1111;
      pulse(4'b1111, 4'b0000);
      do_ready();
      for (int v = 0; v < NV; v++) set_base(v, 'h600);
      pulse(4'b1111, 4'b0000);
      do_ready();
      set_base(0, 'h700); set_base(1, 'h701);
      pulse(4'b0011, 4'b1100);
      do_ready();
      set_base(1, 'h100);
      do_ready();
      do_ready();
      pulse(4'b0010, 4'b0010);
      do_ready();
      do_ready();
      for (int i = 0; i < 30; i++) begin
         loop = NV'($urandom);
         for (int v = 0; v < NV; v++) set_base(v, 'h1000 + $urandom_range(0, 12));
         if ($urandom_range(0, 2) == 0) pulse(NV'($urandom), NV'($urandom));
         if ($urandom_range(0, 3) == 0) pulse(NV'($urandom), 0);
         do_ready();
      end
      rbase = AW'('h2000);
      record = 1;
      for (int i = 0; i < 10; i++) begin
         mic = 8'hA1 + 8'(i);
         do_ready();
      end
      record = 0;
      set_base(0, 'h2000);
      loop = 0;
      pulse(4'b0001, 4'b1110);
      for (int i = 0; i < 9; i++) do_ready();
      record = 1;
      for (int i = 0; i < 4; i++) begin
         mic = 8'(32'($urandom));
         do_ready();
      end
      record = 0;
      set_base(0, 'h100);
      loop = 4'b0001;
      pulse(4'b0001, 4'b0000);
      m_ov = 1;
      model_ready();
      ready = 1;
      @(posedge clock); #1 ready = 0;
      repeat (2) @(posedge clock);
      #1 ready = 1;
      @(posedge clock); #1 ready = 0;
      repeat (BOUND + 6) @(posedge clock);
      #1 chk("overrun_sticky", overrun, 1);
      ready = 1;
      @(posedge clock); #1 ready = 0;
      repeat (3) @(posedge clock);
      #2 reset_n = 0;
      #1 check_reset_outputs("midframe_reset");
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
      model_reset();
      pulse(4'b0001, 4'b0000);
      do_ready();
      do_ready();
      for (int i = 0; i < 100 && sbq.size() > 0; i++) @(posedge clock);
      #1 chk("scoreboard_drained", sbq.size(), 0);
      chk("writes_drained", wq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
